// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and its storage bank.
// Holds FSM encoding, default geometry and the wait-counter width helper.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DATA_W_DEF  = 32;
  localparam int ADDR_W_DEF  = 5;
  localparam int DEPTH_DEF   = 32;
  localparam int LATENCY_DEF = 2;

  // Counter only ever holds LATENCY-1
  function automatic int cnt_width(input int lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/mem_bank.sv
// Single-port synchronous storage with registered read data.
// Contents are never reset; only the read register is.
module mem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int IW     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              we,
  input  logic              rd,
  input  logic [IW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] bank [DEPTH];

  always_ff @(posedge clk) begin
    if (en && we) begin
      bank[addr] <= wdata;
    end
  end

  // Writes and suppressed reads load zero into the read register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (en) begin
      rdata <= rd ? bank[addr] : '0;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Latency-modelling memory responder with valid/ready request and response.
// Define MEM_RESPONDER_RANGE_EN to flag and suppress addresses >= DEPTH.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = cnt_width(LATENCY);

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              accept;
  logic              commit;
  logic              err;
  logic              err_q;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;

  assign req_ready = rst_n && (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign rsp_err   = err_q;

  // Zero-latency commits straight from the request port
  assign c_we    = (state == IDLE) ? req_we    : lat_we;
  assign c_addr  = (state == IDLE) ? req_addr  : lat_addr;
  assign c_wdata = (state == IDLE) ? req_wdata : lat_wdata;

`ifdef MEM_RESPONDER_RANGE_EN
  assign err = 32'(c_addr) >= 32'(DEPTH);
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    commit  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = RESP;
            commit  = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_d = RESP;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A request still waiting when reset hits is dropped
    if (!rst_n) commit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      if (accept) begin
        lat_we    <= req_we;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (commit) err_q <= err;
    end
  end

  mem_bank #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IW     (IW)
  ) bank_i (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (commit),
    .we    (c_we && !err),
    .rd    (!c_we && !err),
    .addr  (c_addr[IW-1:0]),
    .wdata (c_wdata),
    .rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2/DEPTH=16 and LATENCY=0 instances.
// Expectations for out-of-range requests follow MEM_RESPONDER_RANGE_EN.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [4:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        r0_valid, r0_ready, r0_we;
  logic [4:0]  r0_addr;
  logic [31:0] r0_wdata;
  logic        s0_valid, s0_ready, s0_err;
  logic [31:0] s0_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .DEPTH   (16),
    .LATENCY (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  mem_responder #(
    .DATA_W  (32),
    .ADDR_W  (5),
    .DEPTH   (32),
    .LATENCY (0)
  ) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (r0_valid),
    .req_ready (r0_ready),
    .req_we    (r0_we),
    .req_addr  (r0_addr),
    .req_wdata (r0_wdata),
    .rsp_valid (s0_valid),
    .rsp_ready (s0_ready),
    .rsp_rdata (s0_rdata),
    .rsp_err   (s0_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic we, input logic [4:0] a,
                        input logic [31:0] d, output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    r0_valid = 1'b0; r0_we = 1'b0; r0_addr = '0; r0_wdata = '0;
    s0_ready = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_low: got %b want 0", req_ready);
    end
    tick();
    dut.bank_i.bank[3] = 32'hA5A5_0003;
    rst_n = 1'b1;
    tick();
    checks++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b vld=%b err=%b rd=%h want 1 0 0 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    do_req(1'b0, 5'd3, 32'h0, lat);
    checks++;
    if (lat !== 3 || rsp_rdata !== 32'hA5A5_0003 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL preload_read: got lat=%0d rd=%h err=%b want 3 a5a50003 0",
               lat, rsp_rdata, rsp_err);
    end
    release_rsp();
  endtask

  task automatic test_write_read();
    int lat;
    do_req(1'b1, 5'd7, 32'h1234, lat);
    checks++;
    if (lat !== 3 || rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL write_rsp: got lat=%0d rd=%h err=%b want 3 0 0",
               lat, rsp_rdata, rsp_err);
    end
    release_rsp();
    do_req(1'b0, 5'd7, 32'h0, lat);
    checks++;
    if (lat !== 3 || rsp_rdata !== 32'h1234) begin
      errors++;
      $display("FAIL raw_read: got lat=%0d rd=%h want 3 1234", lat, rsp_rdata);
    end
    release_rsp();
  endtask

  task automatic test_backpressure();
    int lat;
    do_req(1'b0, 5'd7, 32'h0, lat);
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL bp_latency: got %0d want 3", lat);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({rsp_valid, req_ready, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h1234}) begin
        errors++;
        $display("FAIL bp_hold%0d: got vld=%b rdy=%b err=%b rd=%h want 1 0 0 1234",
                 i, rsp_valid, req_ready, rsp_err, rsp_rdata);
      end
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if ({req_ready, rsp_valid} !== 2'b10) begin
      errors++;
      $display("FAIL bp_release: got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vld, rdy;
    logic [31:0] rd3, rd7;
    vld = '0; rdy = '0; rd3 = 'x; rd7 = 'x;
    rsp_ready = 1'b1;
    req_we = 1'b1; req_addr = 5'd2; req_wdata = 32'h22; req_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      vld[k-1] = rsp_valid;
      rdy[k-1] = req_ready;
      if (k == 3) rd3 = rsp_rdata;
      if (k == 7) rd7 = rsp_rdata;
      if (k == 1) req_we = 1'b0;
      if (k == 5) req_valid = 1'b0;
    end
    rsp_ready = 1'b0;
    checks++;
    if (vld !== 8'b0100_0100 || rdy !== 8'b1000_1000) begin
      errors++;
      $display("FAIL b2b_timing: got vld=%b rdy=%b want 01000100 10001000", vld, rdy);
    end
    checks++;
    if (rd3 !== 32'h0 || rd7 !== 32'h22) begin
      errors++;
      $display("FAIL b2b_data: got %h %h want 0 22", rd3, rd7);
    end
  endtask

  task automatic test_reset_mid_wait(input int delay);
    int lat;
    dut.bank_i.bank[5] = 32'h5555_0005;
    req_we = 1'b1; req_addr = 5'd5; req_wdata = 32'hDEAD; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < delay; i++) tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL midrst%0d_state: got vld=%b rdy=%b want 0 1", delay, rsp_valid, req_ready);
    end
    do_req(1'b0, 5'd5, 32'h0, lat);
    checks++;
    if (rsp_rdata !== 32'h5555_0005) begin
      errors++;
      $display("FAIL midrst%0d_bank: got %h want 55550005", delay, rsp_rdata);
    end
    release_rsp();
  endtask

  task automatic test_out_of_range();
    int lat;
    logic        exp_err;
    logic [31:0] exp_b4, exp_rd20;
`ifdef MEM_RESPONDER_RANGE_EN
    exp_err = 1'b1; exp_b4 = 32'h4444_0004; exp_rd20 = 32'h0;
`else
    exp_err = 1'b0; exp_b4 = 32'hBEEF; exp_rd20 = 32'hBEEF;
`endif
    dut.bank_i.bank[4] = 32'h4444_0004;
    do_req(1'b1, 5'd20, 32'hBEEF, lat);
    checks++;
    if (lat !== 3 || rsp_err !== exp_err || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL oor_write: got lat=%0d err=%b rd=%h want 3 %b 0",
               lat, rsp_err, rsp_rdata, exp_err);
    end
    release_rsp();
    do_req(1'b0, 5'd4, 32'h0, lat);
    checks++;
    if (rsp_rdata !== exp_b4 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL oor_bank4: got rd=%h err=%b want %h 0", rsp_rdata, rsp_err, exp_b4);
    end
    release_rsp();
    do_req(1'b0, 5'd20, 32'h0, lat);
    checks++;
    if (lat !== 3 || rsp_rdata !== exp_rd20 || rsp_err !== exp_err) begin
      errors++;
      $display("FAIL oor_read: got lat=%0d rd=%h err=%b want 3 %h %b",
               lat, rsp_rdata, rsp_err, exp_rd20, exp_err);
    end
    release_rsp();
  endtask

  task automatic test_latency0();
    dut0.bank_i.bank[9] = 32'h0909_0909;
    r0_we = 1'b0; r0_addr = 5'd9; r0_valid = 1'b1;
    tick();
    r0_valid = 1'b0;
    checks++;
    if ({s0_valid, r0_ready, s0_rdata} !== {1'b1, 1'b0, 32'h0909_0909}) begin
      errors++;
      $display("FAIL lat0_read: got vld=%b rdy=%b rd=%h want 1 0 09090909",
               s0_valid, r0_ready, s0_rdata);
    end
    s0_ready = 1'b1;
    tick();
    s0_ready = 1'b0;
    r0_we = 1'b1; r0_wdata = 32'h99; r0_valid = 1'b1;
    tick();
    r0_valid = 1'b0;
    checks++;
    if ({s0_valid, s0_err, s0_rdata} !== {1'b1, 1'b0, 32'h0}) begin
      errors++;
      $display("FAIL lat0_write: got vld=%b err=%b rd=%h want 1 0 0", s0_valid, s0_err, s0_rdata);
    end
    s0_ready = 1'b1;
    tick();
    s0_ready = 1'b0;
    r0_we = 1'b0; r0_valid = 1'b1;
    tick();
    r0_valid = 1'b0;
    checks++;
    if ({s0_valid, s0_rdata} !== {1'b1, 32'h99}) begin
      errors++;
      $display("FAIL lat0_raw: got vld=%b rd=%h want 1 99", s0_valid, s0_rdata);
    end
    s0_ready = 1'b1;
    tick();
    s0_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_wait(0);
    test_reset_mid_wait(1);
    test_out_of_range();
    test_latency0();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
